fp_add_scheduler: RTL and testbench

- Shares one combinational single-precision FP adder between NUM_REQ requesters using round-robin arbitration.
- Each requester has a valid/ready request channel carrying operands and rounding mode. All requesters share one valid/ready response channel, tagged with the requester id.
- Contains a 2-stage pipeline: an issue register that drives the adder, then a response register that captures the adder outputs. Sits between the ALU front-end and the adder instance.

---
 rtl/fp_sched_pkg.sv | 34 +++
 rtl/fp_add_scheduler_rr_arbiter.sv | 44 ++++
 rtl/fp_add_scheduler.sv | 153 +++++++++++++++
 tb/tb_fp_add_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// Shared types and helpers for the FP adder scheduler: rounding modes,
// the issue-stage request record and the legal-mode check.
package fp_sched_pkg;

    localparam int FP_W     = 32;
    localparam int RM_W     = 3;
    localparam int MAX_ID_W = 3;

    typedef enum logic [RM_W-1:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rmode_t;

    // id is sized for the largest supported requester count; the top uses the low ID_W bits.
    typedef struct packed {
        logic [FP_W-1:0]     a;
        logic [FP_W-1:0]     b;
        rmode_t              rmode;
        logic [MAX_ID_W-1:0] id;
        logic                bad_mode;
    } fp_req_t;

    function automatic logic is_legal_rmode(input logic [RM_W-1:0] m);
        return (m <= 3'b100);
    endfunction

    function automatic rmode_t sanitize_rmode(input logic [RM_W-1:0] m);
        return is_legal_rmode(m) ? rmode_t'(m) : RNE;
    endfunction

endpackage

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping)
// and proposes the pointer one past the winner when the grant is taken.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);

    logic          w_found;
    logic [PW-1:0] w_gidx;

    // Modulo-N add that stays exact for non-power-of-two N.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        logic [PW:0] s;
        s = {1'b0, base} + (PW+1)'(off);
        if (s >= (PW+1)'(N)) begin
            s = s - (PW+1)'(N);
        end
        return s[PW-1:0];
    endfunction

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < N; k++) begin
            logic [PW-1:0] idx;
            idx = wrap_add(ptr, k);
            if (!w_found && req[idx]) begin
                grant[idx] = 1'b1;
                w_found    = 1'b1;
                w_gidx     = idx;
            end
        end
    end

    assign next_ptr = (advance && w_found) ? wrap_add(w_gidx, 1) : ptr;

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one combinational FP adder between NUM_REQ requesters through an
// issue register (drives the adder) and a response register (captures its result).
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    input  logic [NUM_REQ*RM_W-1:0] req_rmode,
    output logic [FP_W-1:0]         add_a,
    output logic [FP_W-1:0]         add_b,
    output logic [RM_W-1:0]         add_rmode,
    input  logic [FP_W-1:0]         add_result,
    input  logic                    add_overflow,
    input  logic                    add_underflow,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [FP_W-1:0]         rsp_result,
    output logic                    rsp_overflow,
    output logic                    rsp_underflow,
    output logic                    rsp_bad_mode,
    output logic                    busy
);

    // Valid/ready: a beat moves when valid && ready; the sender holds valid and
    // payload stable until it moves. req_ready sees rsp_ready only via the stall chain.

    logic                r_s1_vld;
    fp_req_t             r_s1;
    logic                r_s2_vld;
    logic [ID_W-1:0]     r_s2_id;
    logic                r_s2_bad;
    logic [FP_W-1:0]     r_s2_result;
    logic                r_s2_ovf;
    logic                r_s2_unf;
    logic [ID_W-1:0]     r_rr_ptr;

    logic                w_s2_adv;
    logic                w_s1_adv;
    logic                w_s1_free;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_next_ptr;
    logic                w_hs;
    logic [FP_W-1:0]     w_sel_a;
    logic [FP_W-1:0]     w_sel_b;
    logic [RM_W-1:0]     w_sel_rm;
    logic [ID_W-1:0]     w_sel_id;
    fp_req_t             w_new;
    logic                w_unused_id_hi;

    assign w_s2_adv  = !r_s2_vld || rsp_ready;
    assign w_s1_adv  = r_s1_vld && w_s2_adv;
    assign w_s1_free = !r_s1_vld || w_s2_adv;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (r_rr_ptr),
        .advance  (w_hs),
        .grant    (w_grant),
        .next_ptr (w_next_ptr)
    );

    assign req_ready = w_grant & {NUM_REQ{w_s1_free}};
    assign w_hs      = |req_ready;

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_rm = '0;
        w_sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a  = req_a[i*FP_W +: FP_W];
                w_sel_b  = req_b[i*FP_W +: FP_W];
                w_sel_rm = req_rmode[i*RM_W +: RM_W];
                w_sel_id = ID_W'(i);
            end
        end
    end

    // Reserved modes are flagged and replaced by RNE so the adder only sees legal encodings.
    always_comb begin
        w_new          = '0;
        w_new.a        = w_sel_a;
        w_new.b        = w_sel_b;
        w_new.bad_mode = !is_legal_rmode(w_sel_rm);
        w_new.rmode    = sanitize_rmode(w_sel_rm);
        w_new.id       = MAX_ID_W'(w_sel_id);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else if (w_hs) begin
            r_s1_vld <= 1'b1;
            r_s1     <= w_new;
        end else if (w_s1_adv) begin
            r_s1_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld    <= 1'b0;
            r_s2_id     <= '0;
            r_s2_bad    <= 1'b0;
            r_s2_result <= '0;
            r_s2_ovf    <= 1'b0;
            r_s2_unf    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_vld    <= r_s1_vld;
            r_s2_id     <= r_s1.id[ID_W-1:0];
            r_s2_bad    <= r_s1.bad_mode;
            r_s2_result <= add_result;
            r_s2_ovf    <= add_overflow;
            r_s2_unf    <= add_underflow;
        end
    end

    assign w_unused_id_hi = ^r_s1.id;

    assign add_a         = r_s1.a;
    assign add_b         = r_s1.b;
    assign add_rmode     = r_s1.rmode;

    assign rsp_valid     = r_s2_vld;
    assign rsp_id        = r_s2_id;
    assign rsp_result    = r_s2_result;
    assign rsp_overflow  = r_s2_ovf;
    assign rsp_underflow = r_s2_unf;
    assign rsp_bad_mode  = r_s2_bad;
    assign busy          = r_s1_vld || r_s2_vld;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: directed vector table, multi-cycle corner sequences
// and a randomized run against a queue-based reference of arbitration and responses.
module tb_fp_add_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*3-1:0]  req_rmode;
    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic [2:0]      add_rmode;
    logic [31:0]     add_result;
    logic            add_overflow;
    logic            add_underflow;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_overflow;
    logic            rsp_underflow;
    logic            rsp_bad_mode;
    logic            busy;

    int checks;
    int failures;

    fp_add_scheduler #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rmode(req_rmode),
        .add_a(add_a), .add_b(add_b), .add_rmode(add_rmode),
        .add_result(add_result), .add_overflow(add_overflow), .add_underflow(add_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_underflow(rsp_underflow), .rsp_bad_mode(rsp_bad_mode), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural adder (truncating, flush-to-zero) ----------------
    function automatic real f2r(input logic [31:0] x);
        real r;
        int  ex;
        if (x[30:23] == 8'd0) return 0.0;
        r  = 1.0 + real'(int'({9'd0, x[22:0]})) / 8388608.0;
        ex = int'({24'd0, x[30:23]}) - 127;
        if (ex > 0) for (int k = 0; k < ex; k++) r = r * 2.0;
        else        for (int k = 0; k < -ex; k++) r = r / 2.0;
        return x[31] ? -r : r;
    endfunction

    function automatic logic [33:0] model_add(input logic [31:0] a, input logic [31:0] b);
        real         s;
        logic [63:0] d;
        int          e;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        s   = f2r(a) + f2r(b);
        ovf = 1'b0;
        unf = 1'b0;
        res = 32'd0;
        if (s != 0.0) begin
            d = $realtobits(s);
            e = int'({21'd0, d[62:52]}) - 1023 + 127;
            if (e >= 255)    begin ovf = 1'b1; res = {d[63], 8'hFF, 23'd0}; end
            else if (e <= 0) begin unf = 1'b1; res = {d[63], 31'd0}; end
            else             res = {d[63], e[7:0], d[51:29]};
        end
        return {ovf, unf, res};
    endfunction

    assign {add_overflow, add_underflow, add_result} = model_add(add_a, add_b);

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_rmode = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        req_a[id*32 +: 32]    = a;
        req_b[id*32 +: 32]    = b;
        req_rmode[id*3 +: 3]  = rm;
        req_valid[id]         = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        bad;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        clear_inputs();
        rsp_ready = 1'b1;
        set_req(v.id, v.a, v.b, v.rm);
        @(negedge clk);
        check("vec_req_ready", req_ready, 64'(1) << v.id);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("vec_add_a", add_a, v.a);
        check("vec_add_b", add_b, v.b);
        check("vec_add_rmode", add_rmode, v.bad ? 3'd0 : v.rm);
        check("vec_rsp_not_early", rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("vec_rsp_valid", rsp_valid, 1);
        check("vec_rsp_id", rsp_id, v.id);
        check("vec_rsp_result", rsp_result, v.res);
        check("vec_rsp_flags", {rsp_overflow, rsp_underflow, rsp_bad_mode}, {v.ovf, v.unf, v.bad});
        @(posedge clk); #1;
    endtask

    // ---------------- scoreboard for randomized traffic ----------------
    logic [37:0] exp_q[$];
    logic [31:0] ra[N];
    logic [31:0] rb[N];
    logic [2:0]  rrm[N];
    logic [N-1:0] hs_last;
    int          ref_ptr;
    int          inflight;
    logic        prev_stall;
    logic [37:0] prev_rsp;

    function automatic logic [31:0] rand_fp();
        int         sel;
        logic [7:0] e;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) return 32'd0;
        if (sel == 1)      e = 8'($urandom_range(250, 254));
        else if (sel == 2) e = 8'($urandom_range(1, 3));
        else               e = 8'($urandom_range(110, 145));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic sample_cycle();
        logic [N-1:0] exp_ready;
        logic [37:0]  cur;
        int           g;
        exp_ready = '0;
        g = -1;
        if ((req_valid != '0) && (inflight < 2 || rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ref_ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
            exp_ready[g] = 1'b1;
        end
        check("rnd_req_ready", req_ready, exp_ready);
        check("rnd_busy", busy, inflight != 0);
        if (inflight != 1) check("rnd_rsp_valid", rsp_valid, inflight == 2);

        cur = {1'b0, rsp_id, rsp_bad_mode, rsp_overflow, rsp_underflow, rsp_result};
        if (prev_stall) check("rnd_rsp_stable", {rsp_valid, cur}, {1'b1, prev_rsp});
        prev_stall = rsp_valid && !rsp_ready;
        prev_rsp   = cur;

        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rnd_unexpected_rsp", 1, 0);
            end else begin
                check("rnd_rsp_payload", cur, exp_q.pop_front());
            end
            inflight--;
        end

        hs_last = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (hs_last[i]) begin
                logic [33:0] m;
                m = model_add(ra[i], rb[i]);
                exp_q.push_back({3'(i), (rrm[i] > 3'd4), m[33], m[32], m[31:0]});
                inflight++;
                ref_ptr = (i + 1) % N;
                break;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        clear_inputs();

        vecs[0] = '{0, 32'h3F800000, 32'h3F800000, 3'b000, 32'h40000000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2, 32'h00000000, 32'h00000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1, 32'h3F800000, 32'h40000000, 3'b101, 32'h40400000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{3, 32'h40000000, 32'hC0000000, 3'b001, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'b100, 32'h7F800000, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1, 32'h00800001, 32'h80800000, 3'b111, 32'h00000000, 1'b0, 1'b1, 1'b1};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_add_bus", {add_a, add_b, add_rmode}, 0);
        check("rst_rsp_bus", {rsp_id, rsp_result, rsp_overflow, rsp_underflow, rsp_bad_mode}, 0);
        check("rst_req_ready", req_ready, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Round-robin: all four held high for 8 cycles
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            if (c == 0) for (int i = 0; i < N; i++) set_req(i, 32'h3F800000, 32'h3F800000, 3'b000);
            if (c == 8) req_valid = '0;
            @(negedge clk);
            if (c < 8) check("rr_grant", req_ready, 64'(1) << (c % 4));
            if (c >= 2) begin
                check("rr_rsp_valid", rsp_valid, 1);
                check("rr_rsp_id", rsp_id, (c - 2) % 4);
            end
        end

        // Backpressure: three ops, response channel blocked for four cycles
        do_reset();
        begin
            int           got[$];
            logic [N-1:0] hs;
            hs = '0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (c == 0) begin
                    set_req(0, 32'h3F800000, 32'h3F800000, 3'b000);
                    set_req(1, 32'h3F800000, 32'h40000000, 3'b001);
                    set_req(2, 32'h40000000, 32'h40000000, 3'b010);
                end else begin
                    req_valid = req_valid & ~hs;
                end
                rsp_ready = (c >= 6);
                @(negedge clk);
                hs = req_valid & req_ready;
                if (c >= 2 && c <= 5) begin
                    check("bp_ready_low", req_ready, 0);
                    check("bp_rsp_hold", {rsp_valid, rsp_id, rsp_result}, {1'b1, 2'd0, 32'h40000000});
                end
                if (c == 6) check("bp_simul_ready", req_ready, 4'b0100);
                if (rsp_valid && rsp_ready) got.push_back(int'(rsp_id));
            end
            check("bp_rsp_count", got.size(), 3);
            for (int k = 0; k < got.size() && k < 3; k++) check("bp_rsp_order", got[k], k);
        end

        // Reset while both stages hold an op
        do_reset();
        begin
            logic [N-1:0] hs;
            hs = '0;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                if (c == 0) begin
                    set_req(0, 32'h3F800000, 32'h3F800000, 3'b000);
                    set_req(1, 32'h3F800000, 32'h3F800000, 3'b000);
                end else begin
                    req_valid = req_valid & ~hs;
                end
                @(negedge clk);
                hs = req_valid & req_ready;
            end
            check("midrst_pre_busy", busy, 1);
            check("midrst_pre_rsp_valid", rsp_valid, 1);
            @(posedge clk); #1;
            rst = 1'b1;
            req_valid = '0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("midrst_rsp_valid", rsp_valid, 0);
            check("midrst_busy", busy, 0);
            check("midrst_rsp_result", rsp_result, 0);
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            for (int i = 0; i < N; i++) set_req(i, 32'h3F800000, 32'h3F800000, 3'b000);
            @(negedge clk);
            check("midrst_first_grant", req_ready, 4'b0001);
        end

        // Randomized traffic against the scoreboard
        do_reset();
        hs_last    = '0;
        ref_ptr    = 0;
        inflight   = 0;
        prev_stall = 1'b0;
        prev_rsp   = '0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; rrm[i] = '0; end
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (hs_last[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
                    ra[i]  = rand_fp();
                    rb[i]  = rand_fp();
                    rrm[i] = 3'($urandom_range(0, 7));
                    set_req(i, ra[i], rb[i], rrm[i]);
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            sample_cycle();
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            req_valid = '0;
            rsp_ready = 1'b1;
            @(negedge clk);
            sample_cycle();
        end
        check("rnd_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
